arm7tdmi_fetch: RTL
===================

ARM7TDMI_FETCH -- requirements
Module: arm7tdmi_fetch

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h00000000, meaning first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port thumb_mode  input  1  1 = halfword fetch, PC step 2; 0 = word fetch, PC step 4.
REQ-005 SHALL have port stall  input  1  decode not accepting; head entry held.
REQ-006 SHALL have port flush  input  1  redirect request (branch/exception).
REQ-007 SHALL have port flush_target  input  32  redirect address.
REQ-008 SHALL have port mem_req  output  1  fetch request valid.
REQ-009 SHALL have port mem_addr  output  32  fetch address.
REQ-010 SHALL have port mem_size  output  1  0 = word, 1 = halfword.
REQ-011 SHALL have port mem_ack  input  1  request accepted and mem_rdata valid this cycle.
REQ-012 SHALL have port mem_rdata  input  32  fetched data.
REQ-013 SHALL have port instruction  output  32  head instruction to decode.
REQ-014 SHALL have port pc_out  output  32  address of head instruction.
REQ-015 SHALL have port instr_valid  output  1  head entry valid.

Function
REQ-016 SHALL hold a 2-entry FIFO of {instruction, pc}; instruction/pc_out/instr_valid driven from head; instr_valid = FIFO non-empty.
REQ-017 SHALL pop head in any cycle with instr_valid=1, stall=0, flush=0.
REQ-018 SHALL allow at most one outstanding request; issue only when FIFO count + outstanding < 2.
REQ-019 SHALL keep mem_req, mem_addr, mem_size stable from assertion until the cycle mem_ack=1 (ack in first req cycle allowed).
REQ-020 SHALL ignore mem_ack when mem_req=0.
REQ-021 SHALL push captured data on ack cycle N; entry visible (instr_valid=1) in cycle N+1; push and pop in same cycle legal.
REQ-022 SHALL capture in thumb mode {16'h0, mem_rdata[31:16]} if fetch addr[1]=1 else {16'h0, mem_rdata[15:0]}; ARM mode full word.
REQ-023 SHALL sample mem_size from thumb_mode at issue; entry PC = issued address.
REQ-024 SHALL advance fetch_pc by 4 (ARM) or 2 (Thumb) on each accepted request, 32-bit wrap (32'hFFFFFFFC+4 = 0).
REQ-025 SHALL use FSM states FETCH (may issue), WAIT (request outstanding), DISCARD (outstanding request killed by flush).
REQ-026 SHALL transition FETCH->WAIT on req without ack; WAIT->FETCH on ack; WAIT->DISCARD on flush without ack; DISCARD->FETCH on ack, data dropped.
REQ-027 SHALL on flush: clear FIFO same edge (instr_valid=0 next cycle), set fetch_pc to flush_target with [1:0] cleared (ARM) or [0] cleared (Thumb), per thumb_mode that cycle.
REQ-028 SHALL on flush coinciding with mem_ack drop that data and go to FETCH, no DISCARD.
REQ-029 SHALL give flush priority over stall, pop and push; flush while in DISCARD updates target only.
REQ-030 SHALL issue first redirected request no earlier than cycle after flush (FETCH) or cycle after DISCARD ack.

Reset
REQ-031 SHALL on rst=1: mem_req=0, mem_addr=RESET_VECTOR, mem_size=0, FIFO empty, instr_valid=0, instruction=0, pc_out=0, fetch_pc=RESET_VECTOR, state FETCH.
REQ-032 SHALL on rst mid-transaction abandon outstanding request; following acks ignored per REQ-020.
REQ-033 SHALL assert mem_req no earlier than first cycle after rst deasserts.

Verification
REQ-034 SHALL cover: reset release, ack every cycle, rdata E0820001,E0420001 -> mem_addr 0,4,8; instr_valid with pc_out 0 then 4, in order.
REQ-035 SHALL cover: stall=1 for 5 cycles, zero-wait memory -> FIFO fills to 2, mem_req drops, head E0820001 held, no entry lost on release.
REQ-036 SHALL cover: flush target 32'h00000103 ARM while WAIT -> DISCARD, returned data dropped, next mem_addr 32'h00000100, instr_valid=0 until new data.
REQ-037 SHALL cover: thumb_mode=1 at 0x200, rdata 32'h32054148 -> instructions 0x4148 (pc 0x200) then 0x3205 (pc 0x202), mem_size=1.
REQ-038 SHALL cover: fetch at 32'hFFFFFFFC -> next mem_addr 0; ack held off 3 cycles -> mem_addr constant, single push.
REQ-039 SHALL cover: rst asserted while request outstanding, then ack -> no entry pushed, mem_req=0, restart at RESET_VECTOR.

Source files
------------

// File: rtl/arm7tdmi_fetch.sv
`default_nettype none
// arm7tdmi_fetch: prefetch unit with one outstanding memory request and a
// 2-entry {instruction, pc} queue feeding decode; flush redirects the fetch stream.
module arm7tdmi_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        thumb_mode,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_size,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        req_size_q, req_size_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] instr0_q, instr0_d, instr1_q, instr1_d;
  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;

  logic        issue, push, pop, ack_v;
  logic        cur_size;
  logic [31:0] cur_addr, push_data, redirect_pc;

  always_comb begin
    // A new request is only offered from FETCH; a flush in that cycle suppresses
    // it so the redirected stream starts cleanly on the following cycle.
    issue       = (state_q == FETCH) && (count_q < 2'd2) && !flush;
    mem_req     = !rst && (issue || (state_q == WAIT) || (state_q == DISCARD));
    cur_addr    = (state_q == FETCH) ? fetch_pc_q : req_addr_q;
    cur_size    = (state_q == FETCH) ? thumb_mode : req_size_q;
    mem_addr    = rst ? RESET_VECTOR : cur_addr;
    mem_size    = rst ? 1'b0 : cur_size;
    ack_v       = mem_req && mem_ack;
    push_data   = !cur_size ? mem_rdata :
                  (cur_addr[1] ? {16'h0000, mem_rdata[31:16]} : {16'h0000, mem_rdata[15:0]});
    push        = ack_v && !flush && (state_q != DISCARD);
    pop         = (count_q != 2'd0) && !stall && !flush;
    redirect_pc = thumb_mode ? {flush_target[31:1], 1'b0} : {flush_target[31:2], 2'b00};

    instr_valid = (count_q != 2'd0);
    instruction = instr0_q;
    pc_out      = pc0_q;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    req_size_d = req_size_q;
    case (state_q)
      FETCH: begin
        if (flush) begin
          fetch_pc_d = redirect_pc;
        end else if (issue) begin
          fetch_pc_d = fetch_pc_q + (thumb_mode ? 32'd2 : 32'd4);
          req_addr_d = fetch_pc_q;
          req_size_d = thumb_mode;
          if (!mem_ack) state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          fetch_pc_d = redirect_pc;
          state_d    = mem_ack ? FETCH : DISCARD;
        end else if (mem_ack) begin
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (flush) fetch_pc_d = redirect_pc;
        if (mem_ack) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Queue is kept shift-style: entry 0 is always the head.
  always_comb begin
    count_d  = count_q;
    instr0_d = instr0_q;
    instr1_d = instr1_q;
    pc0_d    = pc0_q;
    pc1_d    = pc1_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            instr0_d = push_data;
            pc0_d    = cur_addr;
          end else begin
            instr1_d = push_data;
            pc1_d    = cur_addr;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          instr0_d = instr1_q;
          pc0_d    = pc1_q;
          count_d  = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            instr0_d = push_data;
            pc0_d    = cur_addr;
          end else begin
            instr0_d = instr1_q;
            pc0_d    = pc1_q;
            instr1_d = push_data;
            pc1_d    = cur_addr;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_VECTOR;
      req_addr_q <= RESET_VECTOR;
      req_size_q <= 1'b0;
      count_q    <= 2'd0;
      instr0_q   <= 32'h0;
      instr1_q   <= 32'h0;
      pc0_q      <= 32'h0;
      pc1_q      <= 32'h0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      req_size_q <= req_size_d;
      count_q    <= count_d;
      instr0_q   <= instr0_d;
      instr1_q   <= instr1_d;
      pc0_q      <= pc0_d;
      pc1_q      <= pc1_d;
    end
  end

endmodule
`default_nettype wire
